// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the CDB writeback arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
//
// Contents: field widths, the 51-bit writeback packet wb_pkt_t, and rr_pick(),
// a round-robin one-hot picker sized for up to MAX_REQ requesters.
package cdb_arbiter_pkg;

    localparam int ROBID_W   = 7;
    localparam int RD_W      = 6;
    localparam int ECAUSE_W  = 5;
    localparam int XLEN      = 32;
    localparam int NREQ_DEF  = 5;
    localparam int DEPTH_DEF = 2;
    localparam int MAX_REQ   = 16;

    typedef struct packed {
        logic                error;
        logic [ECAUSE_W-1:0] ecause;
        logic [ROBID_W-1:0]  robid;
        logic [RD_W-1:0]     rd;
        logic [XLEN-1:0]     result;
    } wb_pkt_t;

    // First set bit of valid at or after ptr, wrapping modulo n. ptr < n is
    // assumed, so a single conditional subtract replaces the modulo.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int unsigned        ptr,
                                                   input int unsigned        n);
        logic [MAX_REQ-1:0] g;
        int unsigned        idx;
        g = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (g == '0 && valid[idx]) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side and CDB-side signal bundle for the CDB arbiter.
// Latency: n/a (wires only).
// Backpressure: req_ready per requester, driven by the arbiter.
//
// Ports: req_valid/req_error/req_ecause/req_robid/req_rd/req_result (FU -> arbiter,
// FU i at slice [W*i +: W]), req_ready (arbiter -> FU), cdb_* and cdb_grant
// (arbiter -> ROB/RS). master = FU/consumer side, slave = arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_error;
    logic [NREQ*ECAUSE_W-1:0] req_ecause;
    logic [NREQ*ROBID_W-1:0]  req_robid;
    logic [NREQ*RD_W-1:0]     req_rd;
    logic [NREQ*XLEN-1:0]     req_result;
    logic [NREQ-1:0]          req_ready;

    logic                     cdb_valid;
    logic                     cdb_error;
    logic [ECAUSE_W-1:0]      cdb_ecause;
    logic [ROBID_W-1:0]       cdb_robid;
    logic [RD_W-1:0]          cdb_rd;
    logic [XLEN-1:0]          cdb_result;
    logic [NREQ-1:0]          cdb_grant;

    modport master (
        output req_valid, req_error, req_ecause, req_robid, req_rd, req_result,
        input  req_ready,
        input  cdb_valid, cdb_error, cdb_ecause, cdb_robid, cdb_rd, cdb_result, cdb_grant
    );

    modport slave (
        input  req_valid, req_error, req_ecause, req_robid, req_rd, req_result,
        output req_ready,
        output cdb_valid, cdb_error, cdb_ecause, cdb_robid, cdb_rd, cdb_result, cdb_grant
    );

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// Per-requester writeback FIFO, DEPTH entries of wb_pkt_t (DEPTH a power of 2).
// Latency: pushed entry visible at dout the cycle after the push.
// Backpressure: none internally; caller must only push when count < DEPTH and pop when count > 0.
//
// Ports: clk, rst (sync, active-high), flush (sync empty), push/din, pop/dout (head), count.
module cdb_arbiter_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  wb_pkt_t                    din,
    input  logic                       pop,
    output wb_pkt_t                    dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_pkt_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Buffered CDB arbiter: per-FU FIFOs, one granted head per cycle onto a registered CDB.
// Latency: packet pushed into an idle FIFO at cycle t appears on the CDB at t+2; one packet/cycle.
// Backpressure: req_ready[i] = FIFO i not full, from registers only; unaccepted packets must be held.
//
// Ports: clk, rst (sync, active-high), rob_flush (empties everything), rob_head (age mode only),
// bus (cdb_arbiter_if.slave: req_* in, req_ready/cdb_*/cdb_grant out).
// Build option: define CDB_ARB_AGE_EN to grant the oldest head (smallest robid - rob_head, mod 128,
// ties to lowest index) instead of round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DEPTH = DEPTH_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               rob_flush,
    input  logic [ROBID_W-1:0] rob_head,
    cdb_arbiter_if.slave       bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW    = $clog2(DEPTH+1);

    wb_pkt_t          in_pkt [NREQ];
    wb_pkt_t          head   [NREQ];
    logic [CW-1:0]    count  [NREQ];
    logic [NREQ-1:0]  ready;
    logic [NREQ-1:0]  cand;
    logic [NREQ-1:0]  push;
    logic [NREQ-1:0]  pop;
    logic [NREQ-1:0]  grant_oh;
    logic [IDX_W-1:0] grant_idx;
    wb_pkt_t          grant_pkt;

    logic [IDX_W-1:0] rr_ptr;
    logic             cdb_valid_q;
    logic [NREQ-1:0]  cdb_grant_q;
    wb_pkt_t          cdb_pkt_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign in_pkt[i] = {bus.req_error[i],
                            bus.req_ecause[i*ECAUSE_W +: ECAUSE_W],
                            bus.req_robid [i*ROBID_W  +: ROBID_W],
                            bus.req_rd    [i*RD_W     +: RD_W],
                            bus.req_result[i*XLEN     +: XLEN]};

        assign ready[i] = (count[i] < CW'(DEPTH));
        assign cand[i]  = (count[i] != '0);
        assign push[i]  = bus.req_valid[i] & ready[i];
        // A flush empties the FIFO anyway; gating keeps the pop intent explicit.
        assign pop[i]   = grant_oh[i] & ~rob_flush;

        cdb_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (rob_flush),
            .push  (push[i]),
            .din   (in_pkt[i]),
            .pop   (pop[i]),
            .dout  (head[i]),
            .count (count[i])
        );
    end

    assign bus.req_ready = ready;

`ifdef CDB_ARB_AGE_EN
    logic [ROBID_W-1:0] age;
    logic [ROBID_W-1:0] best_age;
    logic               found;
    // rr_ptr keeps advancing in age mode but nothing consumes it.
    logic               unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
`else
    logic               unused_rob_head;
    assign unused_rob_head = ^rob_head;
`endif

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_pkt = '0;
`ifdef CDB_ARB_AGE_EN
        age      = '0;
        best_age = '0;
        found    = 1'b0;
        // 7-bit wrap subtract gives distance from the ROB head; strict < keeps ties on the lowest index.
        for (int i = 0; i < NREQ; i++) begin
            age = head[i].robid - rob_head;
            if (cand[i] && (!found || age < best_age)) begin
                found       = 1'b1;
                best_age    = age;
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
            end
        end
`else
        grant_oh = NREQ'(rr_pick(MAX_REQ'(cand), 32'(rr_ptr), NREQ));
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                grant_idx = IDX_W'(i);
                grant_pkt = head[i];
            end
        end
    end

    // Data fields hold when idle or flushed so the bus only toggles on real packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_grant_q <= '0;
            cdb_pkt_q   <= '0;
            rr_ptr      <= '0;
        end else if (rob_flush) begin
            cdb_valid_q <= 1'b0;
            cdb_grant_q <= '0;
            rr_ptr      <= '0;
        end else if (|cand) begin
            cdb_valid_q <= 1'b1;
            cdb_grant_q <= grant_oh;
            cdb_pkt_q   <= grant_pkt;
            rr_ptr      <= (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + IDX_W'(1);
        end else begin
            cdb_valid_q <= 1'b0;
            cdb_grant_q <= '0;
        end
    end

    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_grant  = cdb_grant_q;
    assign bus.cdb_error  = cdb_pkt_q.error;
    assign bus.cdb_ecause = cdb_pkt_q.ecause;
    assign bus.cdb_robid  = cdb_pkt_q.robid;
    assign bus.cdb_rd     = cdb_pkt_q.rd;
    assign bus.cdb_result = cdb_pkt_q.result;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed steps plus random traffic against a queue-based reference.
// Latency: n/a.
// Backpressure: FUs hold a packet until the reference says it was accepted.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 5;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rob_flush = 1'b0;
    logic [6:0]   rob_head = '0;

    cdb_arbiter_if #(.NREQ(N)) bus();

    cdb_arbiter #(.NREQ(N), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .rob_flush (rob_flush),
        .rob_head  (rob_head),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned seq = 0;

    logic [N-1:0] v;
    wb_pkt_t      pk [N];

    // Reference: one queue per FU, rotating priority as a plain integer.
    wb_pkt_t      mq [N][$];
    int           rr;
    logic         known = 1'b0;
    logic         exp_valid;
    logic [N-1:0] exp_grant;
    wb_pkt_t      exp_pkt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic mk(output wb_pkt_t p);
        p.error  = 1'($urandom_range(0, 1));
        p.ecause = 5'($urandom);
        p.robid  = seq[6:0];
        p.rd     = 6'($urandom);
        p.result = $urandom;
        seq++;
    endtask

    task automatic apply();
        bus.req_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.req_error[i]         = pk[i].error;
            bus.req_ecause[i*5 +: 5] = pk[i].ecause;
            bus.req_robid[i*7 +: 7]  = pk[i].robid;
            bus.req_rd[i*6 +: 6]     = pk[i].rd;
            bus.req_result[i*32 +: 32] = pk[i].result;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] acc;
        int g;
        int best;
        int a;
        acc = '0;
        g = -1;
        best = 0;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            exp_valid = 1'b0;
            exp_grant = '0;
            exp_pkt   = '0;
            rr        = 0;
            known     = 1'b1;
        end else if (rob_flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            exp_valid = 1'b0;
            exp_grant = '0;
            rr        = 0;
        end else begin
            for (int i = 0; i < N; i++) acc[i] = v[i] && (mq[i].size() < D);
`ifdef CDB_ARB_AGE_EN
            for (int i = 0; i < N; i++) begin
                if (mq[i].size() > 0) begin
                    a = (int'(mq[i][0].robid) - int'(rob_head) + 128) % 128;
                    if (g < 0 || a < best) begin
                        g = i;
                        best = a;
                    end
                end
            end
`else
            for (int k = 0; k < N; k++) begin
                a = (rr + k) % N;
                if (g < 0 && mq[a].size() > 0) g = a;
            end
`endif
            if (g >= 0) begin
                exp_pkt   = mq[g].pop_front();
                exp_valid = 1'b1;
                exp_grant = N'(1) << g;
                rr        = (g + 1) % N;
            end else begin
                exp_valid = 1'b0;
                exp_grant = '0;
            end
            for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(pk[i]);
        end
    endtask

    // One clock: inputs already set at the falling edge, compare after the rising edge.
    task automatic cycle();
        logic [N-1:0] er;
        er = '0;
        apply();
        if (known) begin
            for (int i = 0; i < N; i++) er[i] = (mq[i].size() < D);
            chk("req_ready", 64'(bus.req_ready), 64'(er));
        end
        model_edge();
        @(posedge clk);
        #1;
        if (known) begin
            chk("cdb_valid",  64'(bus.cdb_valid),  64'(exp_valid));
            chk("cdb_grant",  64'(bus.cdb_grant),  64'(exp_grant));
            chk("cdb_error",  64'(bus.cdb_error),  64'(exp_pkt.error));
            chk("cdb_ecause", 64'(bus.cdb_ecause), 64'(exp_pkt.ecause));
            chk("cdb_robid",  64'(bus.cdb_robid),  64'(exp_pkt.robid));
            chk("cdb_rd",     64'(bus.cdb_rd),     64'(exp_pkt.rd));
            chk("cdb_result", 64'(bus.cdb_result), 64'(exp_pkt.result));
        end
        @(negedge clk);
    endtask

    task automatic next_acc(output logic [N-1:0] acc);
        for (int i = 0; i < N; i++) acc[i] = v[i] && (mq[i].size() < D) && !rob_flush && !rst;
    endtask

    initial begin
        logic [N-1:0] acc;
        v = '0;
        for (int i = 0; i < N; i++) pk[i] = '0;
        apply();
        @(negedge clk);

        // Reset held two cycles, then released.
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_ready",  64'(bus.req_ready), 64'(5'b11111));
        chk("rst_valid",  64'(bus.cdb_valid), 64'd0);
        chk("rst_grant",  64'(bus.cdb_grant), 64'd0);
        chk("rst_result", 64'(bus.cdb_result), 64'd0);

        // Single packet from FU2: two-cycle latency, one-cycle pulse.
        v = 5'b00100;
        mk(pk[2]);
        pk[2].robid  = 7'd5;
        pk[2].rd     = 6'd12;
        pk[2].result = 32'hDEADBEEF;
        cycle();
        v = '0;
        chk("single_t1_valid", 64'(bus.cdb_valid), 64'd0);
        cycle();
        chk("single_t2_valid",  64'(bus.cdb_valid),  64'd1);
        chk("single_t2_grant",  64'(bus.cdb_grant),  64'(5'b00100));
        chk("single_t2_robid",  64'(bus.cdb_robid),  64'd5);
        chk("single_t2_rd",     64'(bus.cdb_rd),     64'd12);
        chk("single_t2_result", 64'(bus.cdb_result), 64'hDEADBEEF);
        cycle();
        chk("single_t3_valid", 64'(bus.cdb_valid), 64'd0);

        // Flush returns the rotation to FU0, then all five push together.
        rob_flush = 1'b1;
        cycle();
        rob_flush = 1'b0;
        v = '1;
        for (int i = 0; i < N; i++) mk(pk[i]);
        cycle();
        v = '0;
        cycle();
        for (int k = 0; k < N; k++) begin
            chk("all5_grant", 64'(bus.cdb_grant), 64'd1 << k);
            cycle();
        end
        chk("all5_t7_valid", 64'(bus.cdb_valid), 64'd0);

        // Saturation: everyone holds valid for 20 cycles.
        v = '1;
        for (int i = 0; i < N; i++) mk(pk[i]);
        for (int s = 0; s < 20; s++) begin
            next_acc(acc);
            cycle();
            for (int i = 0; i < N; i++) if (acc[i]) mk(pk[i]);
            if (s >= 1) chk("sat_valid", 64'(bus.cdb_valid), 64'd1);
        end
        v = '0;
        for (int s = 0; s < 12; s++) cycle();

        // Fill FU0/3/4, then flush with new pushes in the flush cycle.
        v = 5'b11001;
        for (int i = 0; i < N; i++) mk(pk[i]);
        cycle();
        for (int i = 0; i < N; i++) mk(pk[i]);
        cycle();
        for (int i = 0; i < N; i++) mk(pk[i]);
        v = '1;
        rob_flush = 1'b1;
        cycle();
        rob_flush = 1'b0;
        v = '0;
        chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
        chk("flush_ready", 64'(bus.req_ready), 64'(5'b11111));
        for (int s = 0; s < 4; s++) begin
            cycle();
            chk("flush_idle_valid", 64'(bus.cdb_valid), 64'd0);
        end

`ifdef CDB_ARB_AGE_EN
        // Oldest-first: robid 125 is 5 past head 120, robid 2 is 10 past.
        rob_head = 7'd120;
        v = 5'b00011;
        mk(pk[0]);
        mk(pk[1]);
        pk[0].robid = 7'd2;
        pk[1].robid = 7'd125;
        cycle();
        v = '0;
        cycle();
        chk("age_first_grant", 64'(bus.cdb_grant), 64'(5'b00010));
        chk("age_first_robid", 64'(bus.cdb_robid), 64'd125);
        cycle();
        chk("age_second_grant", 64'(bus.cdb_grant), 64'(5'b00001));
        chk("age_second_robid", 64'(bus.cdb_robid), 64'd2);
        cycle();
`endif

        // Random traffic with occasional flushes and one mid-run reset.
        v = '0;
        for (int s = 0; s < 400; s++) begin
            rob_flush = ($urandom_range(0, 31) == 0);
            rst       = (s == 200);
            rob_head  = 7'($urandom);
            next_acc(acc);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !v[i] || rob_flush || rst) begin
                    v[i] = ($urandom_range(0, 9) < 6);
                    mk(pk[i]);
                end
            end
        end
        rst = 1'b0;
        rob_flush = 1'b0;
        v = '0;
        for (int s = 0; s < 12; s++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
